rf_dump_reader: RTL



---
 rtl/rf_dump_reader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rf_dump_reader.sv
// Purpose: walks the register file through one read port and streams every entry out as (index, data) beats.
// Latency: 2 cycles per beat with m_ready held high; done pulses the cycle after the last beat is accepted.
// Backpressure: m_ready low holds a beat stable in SEND indefinitely; abort drops the pending beat without a done pulse.
// Optional build macro RF_DUMP_SKIP_X0_EN: start the walk at index 1 so x0 is never emitted.
module rf_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_reg,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

`ifdef RF_DUMP_SKIP_X0_EN
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
`endif
    // Terminal index; the walk stops here instead of wrapping.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;

    assign busy    = (state_q == S_LOAD) || (state_q == S_SEND);
    assign done    = (state_q == S_DONE);
    // The read port is only steered while a register is being captured.
    assign rd_reg  = (state_q == S_LOAD) ? idx_q : '0;
    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_data  = m_data_q;

    // Next-state and beat register updates; abort wins over acceptance.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = FIRST_IDX;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    idx_d     = '0;
                    m_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    // Snapshot what the read port shows this cycle; x0 is hardwired zero.
                    m_data_d  = (idx_q == '0) ? '0 : rd_data;
                    m_addr_d  = idx_q;
                    m_valid_d = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    idx_d     = '0;
                    m_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and beat registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_data_q  <= m_data_d;
        end
    end

endmodule
